ifetch_mem_responder: RTL

- Memory-side responder for the core's 64-bit fetch/load/store request interface.
- Holds an internal doubleword-addressed RAM mapped at the reset PC region.
- Accepts one request at a time over a valid/ready handshake, waits a programmable latency, then returns the registered read data or write acknowledge on a response valid/ready channel.
- Replaces the zero-latency combinational memory model, so fetch and LSU stall paths get exercised.

---
 rtl/ifetch_mem_responder_if.sv | 24 ++
 rtl/ifetch_mem_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ifetch_mem_responder_if.sv
// Request/response channel between the core's fetch/LSU port and the memory responder.
// Each channel uses valid/ready; the responder side is the slave modport.
interface ifetch_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ifetch_mem_responder.sv
// Single-outstanding doubleword RAM responder: LATENCY cycles from accept to rsp_valid,
// response held until rsp_ready; no new request is taken until the response is consumed.
module ifetch_mem_responder #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2
) (
  input  logic                   i_MEM_clk,
  input  logic                   i_MEM_rst,
  ifetch_mem_responder_if.slave  mem
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  accept, commit;
  logic                  req_ready, rsp_valid;

  logic [63:0]           ram [DEPTH];

  logic [63:0]           in_off;
  logic                  in_ok;
  logic [DEPTH_LOG2-1:0] in_idx;
  logic                  unused_off;

  logic [DEPTH_LOG2-1:0] lat_idx;
  logic                  lat_wen;
  logic [63:0]           lat_wdata;
  logic [7:0]            lat_wmask;
  logic                  lat_ok;

  logic [DEPTH_LOG2-1:0] c_idx;
  logic                  c_wen;
  logic [63:0]           c_wdata;
  logic [7:0]            c_wmask;
  logic                  c_ok;

  logic [63:0]           rdata;
  logic                  err;

  assign in_off     = mem.req_addr - BASE_ADDR;
  assign in_ok      = (mem.req_addr >= BASE_ADDR) && (in_off[63:DEPTH_LOG2+3] == '0);
  assign in_idx     = in_off[DEPTH_LOG2+2:3];
  assign unused_off = ^in_off[2:0];

  always_ff @(posedge i_MEM_clk) begin
    if (i_MEM_rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (mem.req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (mem.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_MEM_clk) begin
    if (accept) begin
      lat_idx   <= in_idx;
      lat_wen   <= mem.req_wen;
      lat_wdata <= mem.req_wdata;
      lat_wmask <= mem.req_wmask;
      lat_ok    <= in_ok;
    end
  end

  // With LATENCY==1 the commit happens on the accept edge itself, so use the live request.
  always_comb begin
    c_idx   = lat_idx;
    c_wen   = lat_wen;
    c_wdata = lat_wdata;
    c_wmask = lat_wmask;
    c_ok    = lat_ok;
    if (state == IDLE) begin
      c_idx   = in_idx;
      c_wen   = mem.req_wen;
      c_wdata = mem.req_wdata;
      c_wmask = mem.req_wmask;
      c_ok    = in_ok;
    end
  end

  always_ff @(posedge i_MEM_clk) begin
    if (i_MEM_rst) begin
      rdata <= 64'd0;
      err   <= 1'b0;
    end else if (commit) begin
      err   <= ~c_ok;
      rdata <= (c_ok && !c_wen) ? ram[c_idx] : 64'd0;
    end
  end

  // RAM has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge i_MEM_clk) begin
    if (commit && c_wen && c_ok && !i_MEM_rst) begin
      for (int b = 0; b < 8; b++) begin
        if (c_wmask[b]) ram[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
      end
    end
  end

  assign mem.req_ready = req_ready;
  assign mem.rsp_valid = rsp_valid;
  assign mem.rsp_rdata = rdata;
  assign mem.rsp_err   = err;

endmodule
